mem_cache_controller: RTL and testbench

// - 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
// - The pipeline presents word accesses (MEM_R_EN / MEM_W_EN). Read hits complete combinationally.
// - Misses and all writes go to the SRAM controller through a req/ready handshake.
// - ready low freezes the pipeline.

---
 rtl/mem_cache_pkg.sv | 23 ++
 rtl/cache_set_array.sv | 60 ++++++
 rtl/mem_cache_controller.sv | 143 ++++++++++++++
 tb/tb_mem_cache_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cache_pkg.sv
// Shared types and geometry for the 2-way write-through data cache.
// Address offset layout: [2] word select, [8:3] set index, [18:9] tag.
package mem_cache_pkg;

   localparam int          SETS      = 64;
   localparam int          IDX_W     = $clog2(SETS);
   localparam int          TAG_W     = 10;
   localparam int          OFF_W     = 3 + IDX_W + TAG_W;
   localparam logic [31:0] ADDR_BASE = 32'd1024;

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      WR
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [63:0]      data;
   } line_t;

endpackage

// File: rtl/cache_set_array.sv
// Storage for two ways of {valid, tag, 64-bit block} per set plus one LRU bit.
// Asynchronous read by index; synchronous fill, word update and LRU writes.
module cache_set_array
   import mem_cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] index,
   output line_t            way0,
   output line_t            way1,
   output logic             lru,
   input  logic             fill_en,
   input  logic             fill_way,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic [63:0]      fill_data,
   input  logic             upd_en,
   input  logic             upd_way,
   input  logic             upd_word,
   input  logic [31:0]      upd_data,
   input  logic             lru_en,
   input  logic             lru_val
);

   logic [SETS-1:0]  valid0_q;
   logic [SETS-1:0]  valid1_q;
   logic [SETS-1:0]  lru_q;
   logic [TAG_W-1:0] tag_mem  [2][SETS];
   logic [63:0]      data_mem [2][SETS];

   // NOTE: only valid and LRU bits are reset; tag/data stay plain RAM because a
   // cleared valid bit already makes their contents unobservable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
      end else begin
         if (fill_en) begin
            if (fill_way) valid1_q[index] <= 1'b1;
            else          valid0_q[index] <= 1'b1;
         end
         if (lru_en) lru_q[index] <= lru_val;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[fill_way][index]  <= fill_tag;
         data_mem[fill_way][index] <= fill_data;
      end else if (upd_en) begin
         if (upd_word) data_mem[upd_way][index][63:32] <= upd_data;
         else          data_mem[upd_way][index][31:0]  <= upd_data;
      end
   end

   assign way0 = {valid0_q[index], tag_mem[0][index], data_mem[0][index]};
   assign way1 = {valid1_q[index], tag_mem[1][index], data_mem[1][index]};
   assign lru  = lru_q[index];

endmodule

// File: rtl/mem_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller. Read hits complete combinationally.
module mem_cache_controller
   import mem_cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        write,
   output logic        read,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);

   state_t state_q, state_d;

   logic [OFF_W-1:0] a_off;
   logic             word_sel;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;
   logic             unused_bits;

   line_t way0, way1;
   logic  lru;
   logic  hit0, hit1, hit;
   logic  victim;

   logic        fill_en, upd_en, lru_en, lru_val;
   logic [31:0] hit_word;

   // Low bits of a difference depend only on low bits of the operands.
   assign a_off       = address[OFF_W-1:0] - ADDR_BASE[OFF_W-1:0];
   assign word_sel    = a_off[2];
   assign index       = a_off[3 +: IDX_W];
   assign tag         = a_off[3+IDX_W +: TAG_W];
   assign unused_bits = ^{address[31:OFF_W], a_off[1:0]};

   assign sram_address = address;
   assign sram_wdata   = wdata;

   cache_set_array u_array (
      .clk       (clk),
      .rst       (rst),
      .index     (index),
      .way0      (way0),
      .way1      (way1),
      .lru       (lru),
      .fill_en   (fill_en),
      .fill_way  (victim),
      .fill_tag  (tag),
      .fill_data (sram_rdata),
      .upd_en    (upd_en),
      .upd_way   (hit1),
      .upd_word  (word_sel),
      .upd_data  (wdata),
      .lru_en    (lru_en),
      .lru_val   (lru_val)
   );

   assign hit0 = way0.valid && (way0.tag == tag);
   assign hit1 = way1.valid && (way1.tag == tag);
   assign hit  = hit0 | hit1;

   // Fill an empty way first (way0 preferred); otherwise evict the LRU way.
   assign victim = !way0.valid ? 1'b0 :
                   !way1.valid ? 1'b1 : lru;

   assign hit_word = hit1 ? (word_sel ? way1.data[63:32] : way1.data[31:0])
                          : (word_sel ? way0.data[63:32] : way0.data[31:0]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every output of this block gets a default before any branch, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      ready   = 1'b1;
      read    = 1'b0;
      write   = 1'b0;
      rdata   = '0;
      fill_en = 1'b0;
      upd_en  = 1'b0;
      lru_en  = 1'b0;
      lru_val = 1'b0;
      // While reset is held, outputs show the idle view even if a request is up.
      if (rst) begin
         unique case (state_q)
            IDLE: begin
               if (MEM_W_EN) begin
                  ready   = 1'b0;
                  write   = 1'b1;
                  state_d = WR;
                  upd_en  = hit;
                  lru_en  = hit;
                  lru_val = hit0;
               end else if (MEM_R_EN) begin
                  if (hit) begin
                     rdata   = hit_word;
                     lru_en  = 1'b1;
                     lru_val = hit0;
                  end else begin
                     ready   = 1'b0;
                     read    = 1'b1;
                     state_d = RD_MISS;
                  end
               end
            end
            RD_MISS: begin
               read  = 1'b1;
               ready = 1'b0;
               if (sram_ready) begin
                  ready   = 1'b1;
                  rdata   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                  fill_en = 1'b1;
                  lru_en  = 1'b1;
                  lru_val = ~victim;
                  state_d = IDLE;
               end
            end
            WR: begin
               write = 1'b1;
               ready = 1'b0;
               if (sram_ready) begin
                  ready   = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_cache_controller.sv
// Scoreboard bench for mem_cache_controller: the driver queues expected
// completions, a monitor pops and compares whenever an access completes.
module tb_mem_cache_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        write;
   logic        read;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   typedef struct {
      bit          is_write;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem [int unsigned];
   int          tests = 0;
   int          fails = 0;
   bit          rst_seen = 1'b0;

   localparam int SRAM_LAT = 3;

   mem_cache_controller dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .wdata        (wdata),
      .MEM_R_EN     (MEM_R_EN),
      .MEM_W_EN     (MEM_W_EN),
      .rdata        (rdata),
      .ready        (ready),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .write        (write),
      .read         (read),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   always #5 clk = ~clk;

   always @(negedge rst) rst_seen = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'd0;
   endfunction

   // SRAM model: answers each request after SRAM_LAT cycles with a one-cycle
   // sram_ready pulse; a reset during the wait abandons the request.
   initial begin
      sram_ready = 1'b0;
      sram_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && (read === 1'b1 || write === 1'b1)) begin
            rst_seen = 1'b0;
            repeat (SRAM_LAT) @(posedge clk);
            #1;
            if (!rst_seen && rst === 1'b1) begin
               if (write) begin
                  mem[sram_address & ~32'd3] = sram_wdata;
               end else begin
                  sram_rdata = {mem_rd((sram_address & ~32'd7) + 32'd4),
                                mem_rd(sram_address & ~32'd7)};
               end
               sram_ready = 1'b1;
               @(posedge clk);
               #1;
               sram_ready = 1'b0;
            end
         end
      end
   end

   // Monitor: every completed access must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && ready === 1'b1 && (MEM_R_EN === 1'b1 || MEM_W_EN === 1'b1)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_completion_queue_size", exp_q.size(), 1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("completion_kind_is_write", {31'd0, MEM_W_EN}, {31'd0, e.is_write});
               check("completion_rdata", rdata, e.rdata);
            end
         end
      end
   end

   task automatic wait_done(input string name);
      int n = 0;
      while (ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) check({name, "_timeout"}, {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [31:0] addr,
                          input logic [31:0] exp, input bit exp_hit);
      @(posedge clk);
      #1;
      address  = addr;
      MEM_R_EN = 1'b1;
      MEM_W_EN = 1'b0;
      exp_q.push_back('{is_write: 1'b0, rdata: exp});
      @(negedge clk);
      check({name, "_ready"}, {31'd0, ready}, exp_hit ? 32'd1 : 32'd0);
      check({name, "_read"},  {31'd0, read},  exp_hit ? 32'd0 : 32'd1);
      wait_done(name);
   endtask

   task automatic do_write(input string name, input logic [31:0] addr,
                           input logic [31:0] data, input bit also_read);
      @(posedge clk);
      #1;
      address  = addr;
      wdata    = data;
      MEM_W_EN = 1'b1;
      MEM_R_EN = also_read;
      exp_q.push_back('{is_write: 1'b1, rdata: 32'd0});
      @(negedge clk);
      check({name, "_ready"}, {31'd0, ready}, 32'd0);
      check({name, "_write"}, {31'd0, write}, 32'd1);
      check({name, "_read"},  {31'd0, read},  32'd0);
      wait_done(name);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      mem[32'h400] = 32'hAAAA_0001;
      mem[32'h404] = 32'hBBBB_0002;
      mem[32'h600] = 32'h6666_0000;
      mem[32'h604] = 32'h6666_0004;
      mem[32'h800] = 32'h8888_0000;
      mem[32'h804] = 32'h8888_0004;

      rst      = 1'b0;
      address  = '0;
      wdata    = '0;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", {31'd0, ready}, 32'd1);
      check("reset_read",  {31'd0, read},  32'd0);
      check("reset_write", {31'd0, write}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Cold miss fills the block; the neighbouring word then hits.
      do_read("cold_rd_400", 32'h400, 32'hAAAA_0001, 1'b0);
      do_read("hit_rd_404",  32'h404, 32'hBBBB_0002, 1'b1);

      // Store hit updates the cached word as well as SRAM.
      do_write("st_hit_400", 32'h400, 32'h1234_5678, 1'b0);
      do_read("rd_after_st_400", 32'h400, 32'h1234_5678, 1'b1);

      // Store miss does not allocate.
      do_write("st_miss_800", 32'h800, 32'hDEAD_0800, 1'b0);
      do_read("rd_miss_800", 32'h800, 32'hDEAD_0800, 1'b0);

      // Reset during a read miss: outputs go idle at once and no line is filled.
      @(posedge clk);
      #1;
      address  = 32'h600;
      MEM_R_EN = 1'b1;
      @(negedge clk);
      check("abort_rd_600_read", {31'd0, read}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_read",  {31'd0, read},  32'd0);
      check("abort_write", {31'd0, write}, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      MEM_R_EN = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      do_read("rd_600_after_abort", 32'h600, 32'h6666_0000, 1'b0);

      // Conflict set: 0x400, 0x600, 0x800 all map to index 0.
      pulse_reset();
      do_read("cf_rd_400", 32'h400, 32'h1234_5678, 1'b0);
      do_read("cf_rd_600", 32'h600, 32'h6666_0000, 1'b0);
      do_read("cf_hit_400", 32'h400, 32'h1234_5678, 1'b1);
      do_read("cf_rd_800", 32'h800, 32'hDEAD_0800, 1'b0);
      do_read("cf_hit_400_again", 32'h400, 32'h1234_5678, 1'b1);
      do_read("cf_miss_600_evicted", 32'h600, 32'h6666_0000, 1'b0);

      // Read and write together: the write wins.
      do_write("rw_both_400", 32'h400, 32'hCAFE_F00D, 1'b1);
      do_read("rd_after_rw_400", 32'h400, 32'hCAFE_F00D, 1'b1);

      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
